// File: rtl/load_store_unit_if.sv
// Data-memory port of the load/store unit: variable-latency req/ready handshake.
// The LSU drives the request side through the master modport; the memory model uses slave.
interface load_store_unit_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
);
    logic                     mem_req;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic [3:0]               mem_be;
    logic                     mem_ready;
    logic [DATA_WIDTH-1:0]    mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store engine: lane-aligns stores, extends loads, and stalls the
// pipeline across an IDLE -> BUSY -> DONE access on a variable-latency memory port.
module load_store_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] i_aluresultm,
    input  logic [DATA_WIDTH-1:0]    i_writedatam,
    input  logic                     i_memreadm,
    input  logic                     i_memwritem,
    input  logic [2:0]               i_funct3m,
    load_store_unit_if.master        mem,
    output logic [DATA_WIDTH-1:0]    o_readdatam,
    output logic                     o_stallm,
    output logic                     o_misalignm
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic                     r_req;
    logic                     r_we;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [3:0]               r_be;
    logic [2:0]               r_funct3;
    logic [1:0]               r_lane;
    logic [DATA_WIDTH-1:0]    r_readdata;
    logic                     w_access;
    logic                     w_aligned;
    logic                     w_start;

    // funct3[1:0] selects size for every code: 00 byte, 01 half, anything else word.
    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'b00:   lane_be = 4'b0001 << lane;
            2'b01:   lane_be = lane[1] ? 4'b1100 : 4'b0011;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] lane_wdata(input logic [2:0] f3,
                                                         input logic [DATA_WIDTH-1:0] d);
        case (f3[1:0])
            2'b00:   lane_wdata = {4{d[7:0]}};
            2'b01:   lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [2:0] f3,
                                                          input logic [1:0] lane,
                                                          input logic [DATA_WIDTH-1:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{lane, 3'b000} +: 8];
        h = rd[{lane[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b100:  load_extend = {24'd0, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b101:  load_extend = {16'd0, h};
            default: load_extend = rd;
        endcase
    endfunction

    always_comb begin
        w_next      = r_state;
        o_stallm    = 1'b0;
        o_misalignm = 1'b0;
        w_access    = i_memreadm | i_memwritem;
        case (i_funct3m[1:0])
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = ~i_aluresultm[0];
            default: w_aligned = (i_aluresultm[1:0] == 2'b00);
        endcase
        w_start = (r_state == IDLE) & w_access & w_aligned;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next   = BUSY;
                    o_stallm = 1'b1;
                end
                o_misalignm = w_access & ~w_aligned;
            end
            BUSY: begin
                // Held through the ready cycle so the loaded value is captured in DONE.
                o_stallm = 1'b1;
                if (mem.mem_ready) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (rst) begin
            o_stallm    = 1'b0;
            o_misalignm = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= 4'b0000;
            r_funct3   <= 3'b000;
            r_lane     <= 2'b00;
            r_readdata <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (w_start) begin
                    r_req    <= 1'b1;
                    r_we     <= i_memwritem;
                    r_addr   <= {i_aluresultm[ADDRESS_WIDTH-1:2], 2'b00};
                    r_wdata  <= lane_wdata(i_funct3m, i_writedatam);
                    r_be     <= lane_be(i_funct3m, i_aluresultm[1:0]);
                    r_funct3 <= i_funct3m;
                    r_lane   <= i_aluresultm[1:0];
                end
                BUSY: if (mem.mem_ready) begin
                    r_req <= 1'b0;
                    r_we  <= 1'b0;
                    r_be  <= 4'b0000;
                    if (!r_we) r_readdata <= load_extend(r_funct3, r_lane, mem.mem_rdata);
                end
                default: ;
            endcase
        end
    end

    assign mem.mem_req   = r_req;
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_wdata = r_wdata;
    assign mem.mem_be    = r_be;
    assign o_readdatam   = r_readdata;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: issued requests go to a scoreboard queue and are
// compared when the memory handshake completes; pipeline outputs are checked per cycle.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] aluresultm;
    logic [31:0] writedatam;
    logic        memreadm;
    logic        memwritem;
    logic [2:0]  funct3m;
    logic [31:0] readdatam;
    logic        stallm;
    logic        misalignm;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;
    req_t sb_q[$];

    load_store_unit_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) mem ();

    load_store_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_aluresultm (aluresultm),
        .i_writedatam (writedatam),
        .i_memreadm   (memreadm),
        .i_memwritem  (memwritem),
        .i_funct3m    (funct3m),
        .mem          (mem),
        .o_readdatam  (readdatam),
        .o_stallm     (stallm),
        .o_misalignm  (misalignm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: each completed handshake must match the oldest issued request.
    always @(negedge clk) begin
        if (mem.mem_req === 1'b1 && mem.mem_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_req", 32'd1, 32'd0);
            end else begin
                req_t e;
                e = sb_q.pop_front();
                chk("sb_we",    {31'd0, mem.mem_we}, {31'd0, e.we});
                chk("sb_addr",  mem.mem_addr, e.addr);
                chk("sb_wdata", mem.mem_wdata, e.wdata);
                chk("sb_be",    {28'd0, mem.mem_be}, {28'd0, e.be});
            end
        end
    end

    task automatic do_access(input string tag, input logic we, input logic rd,
                             input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input int lat,
                             input logic [31:0] rdata, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata, input logic [31:0] exp_rd);
        int   nstall;
        req_t e;
        nstall = 0;
        @(posedge clk); #1;
        memreadm = rd; memwritem = we; funct3m = f3; aluresultm = addr; writedatam = wdata;
        e.we = we; e.addr = {addr[31:2], 2'b00}; e.wdata = exp_wdata; e.be = exp_be;
        sb_q.push_back(e);
        #1;
        chk({tag, "_idle_req"}, {31'd0, mem.mem_req}, 32'd0);
        chk({tag, "_idle_stall"}, {31'd0, stallm}, 32'd1);
        chk({tag, "_idle_misalign"}, {31'd0, misalignm}, 32'd0);
        if (stallm === 1'b1) nstall++;
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            if (k == lat) begin
                mem.mem_ready = 1'b1;
                mem.mem_rdata = rdata;
            end else begin
                mem.mem_rdata = $urandom;
            end
            #1;
            chk({tag, "_busy_req"}, {31'd0, mem.mem_req}, 32'd1);
            chk({tag, "_busy_addr"}, mem.mem_addr, {addr[31:2], 2'b00});
            chk({tag, "_busy_stall"}, {31'd0, stallm}, 32'd1);
            if (stallm === 1'b1) nstall++;
        end
        @(posedge clk); #1;
        mem.mem_ready = 1'b0;
        mem.mem_rdata = $urandom;
        #1;
        chk({tag, "_done_req"}, {31'd0, mem.mem_req}, 32'd0);
        chk({tag, "_done_we"}, {31'd0, mem.mem_we}, 32'd0);
        chk({tag, "_done_be"}, {28'd0, mem.mem_be}, 32'd0);
        chk({tag, "_done_stall"}, {31'd0, stallm}, 32'd0);
        chk({tag, "_readdata"}, readdatam, exp_rd);
        chk({tag, "_stall_cycles"}, nstall, lat + 1);
        @(posedge clk); #1;
        memreadm = 1'b0; memwritem = 1'b0;
        #1;
        chk({tag, "_after_req"}, {31'd0, mem.mem_req}, 32'd0);
        chk({tag, "_after_readdata"}, readdatam, exp_rd);
    endtask

    task automatic do_misalign(input string tag, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] exp_rd);
        @(posedge clk); #1;
        memreadm = ~we; memwritem = we; funct3m = f3; aluresultm = addr; writedatam = 32'h1111_2222;
        #1;
        chk({tag, "_misalign"}, {31'd0, misalignm}, 32'd1);
        chk({tag, "_stall"}, {31'd0, stallm}, 32'd0);
        chk({tag, "_req"}, {31'd0, mem.mem_req}, 32'd0);
        @(posedge clk); #1;
        memreadm = 1'b0; memwritem = 1'b0;
        #1;
        chk({tag, "_req_next"}, {31'd0, mem.mem_req}, 32'd0);
        chk({tag, "_misalign_next"}, {31'd0, misalignm}, 32'd0);
        chk({tag, "_readdata"}, readdatam, exp_rd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        mem.mem_ready = 1'b0;
        mem.mem_rdata = 32'd0;
        memreadm = 1'b1; memwritem = 1'b0; funct3m = 3'b010;
        aluresultm = 32'h0000_0001; writedatam = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall_forced", {31'd0, stallm}, 32'd0);
        chk("rst_misalign_forced", {31'd0, misalignm}, 32'd0);
        aluresultm = 32'h0000_0000;
        #1;
        chk("rst_stall_aligned", {31'd0, stallm}, 32'd0);
        chk("rst_req", {31'd0, mem.mem_req}, 32'd0);
        chk("rst_we", {31'd0, mem.mem_we}, 32'd0);
        chk("rst_be", {28'd0, mem.mem_be}, 32'd0);
        chk("rst_addr", mem.mem_addr, 32'd0);
        chk("rst_wdata", mem.mem_wdata, 32'd0);
        chk("rst_readdata", readdatam, 32'd0);
        memreadm = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        do_access("sw",  1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 1, 32'h0,
                  4'b1111, 32'hDEAD_BEEF, 32'h0000_0000);
        do_access("lb",  1'b0, 1'b1, 3'b000, 32'h0000_0202, 32'h0, 1, 32'h12F0_3456,
                  4'b0100, 32'h0, 32'hFFFF_FFF0);
        do_access("sb",  1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0000_00A5, 2, 32'h0,
                  4'b1000, 32'hA5A5_A5A5, 32'hFFFF_FFF0);
        do_access("lbu", 1'b0, 1'b1, 3'b100, 32'h0000_0202, 32'h0, 1, 32'h12F0_3456,
                  4'b0100, 32'h0, 32'h0000_00F0);
        do_access("lhu", 1'b0, 1'b1, 3'b101, 32'h0000_0202, 32'h0, 1, 32'h12F0_3456,
                  4'b1100, 32'h0, 32'h0000_12F0);
        do_access("lh",  1'b0, 1'b1, 3'b001, 32'h0000_0200, 32'h0, 3, 32'h1234_8001,
                  4'b0011, 32'h0, 32'hFFFF_8001);
        do_access("sh_rdwr", 1'b1, 1'b1, 3'b001, 32'h0000_0106, 32'h0000_BEEF, 1, 32'h7777_7777,
                  4'b1100, 32'hBEEF_BEEF, 32'hFFFF_8001);
        do_access("lw_slow", 1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'h0, 4, 32'hCAFE_F00D,
                  4'b1111, 32'h0, 32'hCAFE_F00D);

        do_misalign("mis_lw",  1'b0, 3'b010, 32'h0000_0301, 32'hCAFE_F00D);
        do_misalign("mis_lh",  1'b0, 3'b001, 32'h0000_0203, 32'hCAFE_F00D);
        do_misalign("mis_f3_011", 1'b0, 3'b011, 32'h0000_0302, 32'hCAFE_F00D);
        do_misalign("mis_sw",  1'b1, 3'b010, 32'h0000_0106, 32'hCAFE_F00D);

        // Reset in the middle of an access; a late ready must not produce a result.
        @(posedge clk); #1;
        memreadm = 1'b1; memwritem = 1'b0; funct3m = 3'b010; aluresultm = 32'h0000_0300;
        #1;
        chk("rstmid_idle_stall", {31'd0, stallm}, 32'd1);
        @(posedge clk); #1;
        chk("rstmid_busy_req", {31'd0, mem.mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmid_stall_forced", {31'd0, stallm}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        memreadm = 1'b0;
        mem.mem_ready = 1'b1;
        mem.mem_rdata = 32'h5555_5555;
        #1;
        chk("rstmid_req_dropped", {31'd0, mem.mem_req}, 32'd0);
        chk("rstmid_readdata_cleared", readdatam, 32'd0);
        chk("rstmid_stall_idle", {31'd0, stallm}, 32'd0);
        @(posedge clk); #1;
        mem.mem_ready = 1'b0;
        #1;
        chk("rstmid_late_ready_ignored", readdatam, 32'd0);
        chk("rstmid_req_still_low", {31'd0, mem.mem_req}, 32'd0);
        chk("sb_queue_drained", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
